// File: rtl/data_sram_responder_pkg.sv
// Shared constants and types for the data-SRAM responder slice.
// Defaults for array size and read latency live here so top-level wrappers agree.
package data_sram_responder_pkg;

    localparam int DSRAM_ADDR_WD = 12;
    localparam int DSRAM_RD_LAT  = 1;
    localparam int DSRAM_LANES   = 4;
    localparam int DSRAM_WORD_WD = 8 * DSRAM_LANES;

    // One slot of the read-return delay line.
    typedef struct packed {
        logic                     vld;
        logic [DSRAM_WORD_WD-1:0] dat;
    } rd_stage_t;

endpackage

// File: rtl/data_sram_responder_if.sv
// Data-SRAM request/response bundle between the execute/memory stages and the responder.
// Requests have no backpressure; responses are a single-cycle rvalid strobe.
interface data_sram_responder_if;
    import data_sram_responder_pkg::*;

    logic                     data_sram_en;
    logic [DSRAM_LANES-1:0]   data_sram_we;
    logic [31:0]              data_sram_addr;
    logic [DSRAM_WORD_WD-1:0] data_sram_wdata;
    logic [DSRAM_WORD_WD-1:0] data_sram_rdata;
    logic                     data_sram_rvalid;

    modport master (
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  data_sram_rvalid
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output data_sram_rvalid
    );

endinterface

// File: rtl/data_sram_responder_lat_pipe.sv
// DEPTH-stage valid/data delay line; stage 0 captures the array read, synchronous clear.
// Data in each stage only advances with a valid, so the output word holds between results.
module data_sram_responder_lat_pipe
    import data_sram_responder_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_vld_i,
    input  logic [DSRAM_WORD_WD-1:0] in_dat_i,
    output logic                     out_vld_o,
    output logic [DSRAM_WORD_WD-1:0] out_dat_o
);

    rd_stage_t stage_q [DEPTH];
    rd_stage_t stage_d [DEPTH];

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        stage_d[0].vld = in_vld_i;
        if (in_vld_i) begin
            stage_d[0].dat = in_dat_i;
        end
        for (int k = 1; k < DEPTH; k++) begin
            stage_d[k].vld = stage_q[k-1].vld;
            if (stage_q[k-1].vld) begin
                stage_d[k].dat = stage_q[k-1].dat;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (reset) begin
                stage_q[k] <= '0;
            end else begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_vld_o = stage_q[DEPTH-1].vld;
    assign out_dat_o = stage_q[DEPTH-1].dat;

endmodule

// File: rtl/data_sram_responder.sv
// Word-organised single-port data SRAM with byte-lane writes, RD_LAT-cycle reads and a backdoor preload port.
// One request accepted per enabled cycle, never stalls; reads return in issue order as rvalid pulses.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_WD = DSRAM_ADDR_WD,
    parameter int RD_LAT  = DSRAM_RD_LAT
) (
    input  logic                     clk,
    input  logic                     reset,
    data_sram_responder_if.slave     dsram,
    input  logic                     init_we,
    input  logic [ADDR_WD-1:0]       init_addr,
    input  logic [DSRAM_WORD_WD-1:0] init_wdata
);

    localparam int DEPTH = 1 << ADDR_WD;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("data_sram_responder: RD_LAT must be in 1..4");
    end

    logic [DSRAM_LANES-1:0][7:0] mem_q [DEPTH];

    logic [ADDR_WD-1:0]       widx;
    logic                     rd_req;
    logic                     wr_req;
    logic [DSRAM_WORD_WD-1:0] rd_word;
    logic                     unused_addr_bits;

    // Byte offset and bits above the array are dropped, so addresses alias.
    assign widx             = dsram.data_sram_addr[ADDR_WD+1:2];
    assign unused_addr_bits = ^{dsram.data_sram_addr[1:0], dsram.data_sram_addr >> (ADDR_WD + 2)};

    assign rd_req  = dsram.data_sram_en && (dsram.data_sram_we == '0);
    assign wr_req  = dsram.data_sram_en && (dsram.data_sram_we != '0);
    assign rd_word = mem_q[widx];

    // Front-port lanes are assigned after the backdoor word so they win on a same-word collision.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_addr] <= init_wdata;
        end
        if (wr_req) begin
            for (int i = 0; i < DSRAM_LANES; i++) begin
                if (dsram.data_sram_we[i]) begin
                    mem_q[widx][i] <= dsram.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    data_sram_responder_lat_pipe #(
        .DEPTH (RD_LAT)
    ) u_lat_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_vld_i  (rd_req),
        .in_dat_i  (rd_word),
        .out_vld_o (dsram.data_sram_rvalid),
        .out_dat_o (dsram.data_sram_rdata)
    );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench driving three responders (RD_LAT 1,2,3) in lockstep against a word-array/schedule model.
module tb_data_sram_responder;
    import data_sram_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        init_we;
    logic [11:0] init_addr;
    logic [31:0] init_wdata;

    always #5 clk = ~clk;

    data_sram_responder_if if1 ();
    data_sram_responder_if if2 ();
    data_sram_responder_if if3 ();

    assign if1.data_sram_en = en;  assign if1.data_sram_we = we;
    assign if1.data_sram_addr = addr;  assign if1.data_sram_wdata = wdata;
    assign if2.data_sram_en = en;  assign if2.data_sram_we = we;
    assign if2.data_sram_addr = addr;  assign if2.data_sram_wdata = wdata;
    assign if3.data_sram_en = en;  assign if3.data_sram_we = we;
    assign if3.data_sram_addr = addr;  assign if3.data_sram_wdata = wdata;

    data_sram_responder #(.ADDR_WD(12), .RD_LAT(1)) u_l1 (
        .clk(clk), .reset(reset), .dsram(if1),
        .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata));
    data_sram_responder #(.ADDR_WD(12), .RD_LAT(2)) u_l2 (
        .clk(clk), .reset(reset), .dsram(if2),
        .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata));
    data_sram_responder #(.ADDR_WD(12), .RD_LAT(3)) u_l3 (
        .clk(clk), .reset(reset), .dsram(if3),
        .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata));

    logic        dut_rv [3];
    logic [31:0] dut_rd [3];
    assign dut_rv[0] = if1.data_sram_rvalid;  assign dut_rd[0] = if1.data_sram_rdata;
    assign dut_rv[1] = if2.data_sram_rvalid;  assign dut_rd[1] = if2.data_sram_rdata;
    assign dut_rv[2] = if3.data_sram_rvalid;  assign dut_rd[2] = if3.data_sram_rdata;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int lat, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (lat%0d) at t=%0t: got %h, expected %h", name, lat, $time, act, exp);
        end
    endtask

    // Model: memory as plain words, and a per-latency calendar of expected rvalid pulses.
    logic [31:0] mdl [4096];
    bit          sched_v [3][1024];
    logic [31:0] sched_d [3][1024];
    bit          rst_at  [1024];
    logic [31:0] last    [3];
    int          cyc = 0;
    bit          started = 1'b0;

    task automatic model_step();
        int          w;
        logic [31:0] old;
        w   = int'((addr / 4) % 4096);
        old = mdl[w];
        if (reset) begin
            rst_at[cyc+1] = 1'b1;
            for (int l = 0; l < 3; l++)
                for (int k = 1; k <= 4; k++) sched_v[l][cyc+k] = 1'b0;
        end else if (en && we == 4'b0000) begin
            for (int l = 0; l < 3; l++) begin
                sched_v[l][cyc+l+1] = 1'b1;
                sched_d[l][cyc+l+1] = old;
            end
        end
        if (init_we) mdl[init_addr] = init_wdata;
        if (en && we != 4'b0000)
            for (int i = 0; i < 4; i++)
                if (we[i]) mdl[w][8*i +: 8] = wdata[8*i +: 8];
        cyc++;
    endtask

    task automatic compare_step();
        if (rst_at[cyc]) begin
            started = 1'b1;
            for (int l = 0; l < 3; l++) last[l] = 32'h0;
        end
        if (started) begin
            for (int l = 0; l < 3; l++) begin
                if (sched_v[l][cyc]) last[l] = sched_d[l][cyc];
                chk("rvalid", l + 1, {31'b0, dut_rv[l]}, {31'b0, sched_v[l][cyc]});
                chk("rdata", l + 1, dut_rd[l], last[l]);
            end
        end
    endtask

    always @(posedge clk) model_step();
    always @(negedge clk) compare_step();

    task automatic drv(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       input logic iw, input logic [11:0] ia, input logic [31:0] id);
        en = e; we = w; addr = a; wdata = d;
        init_we = iw; init_addr = ia; init_wdata = id;
        @(negedge clk);
        en = 1'b0; we = 4'h0; init_we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        drv(1'b1, 4'h0, a, 32'h0, 1'b0, 12'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        drv(1'b1, w, a, d, 1'b0, 12'h0, 32'h0);
    endtask

    task automatic preload(input logic [11:0] ia, input logic [31:0] id);
        drv(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, ia, id);
    endtask

    // Read, let every latency drain, then the held rdata of all three must equal exp.
    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        rd(a);
        repeat (4) @(negedge clk);
        for (int l = 0; l < 3; l++) begin
            chk(name, l + 1, dut_rd[l], exp);
            chk({name, "_rv_idle"}, l + 1, {31'b0, dut_rv[l]}, 32'h0);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
        init_we = 1'b0; init_addr = 12'h0; init_wdata = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int l = 0; l < 3; l++) begin
            chk("reset_rvalid", l + 1, {31'b0, dut_rv[l]}, 32'h0);
            chk("reset_rdata", l + 1, dut_rd[l], 32'h0);
        end

        preload(12'h010, 32'h11223344);
        preload(12'h001, 32'h1);
        preload(12'h002, 32'h2);
        preload(12'h003, 32'h3);
        preload(12'h006, 32'h1);
        chk("mdl_w10", 0, mdl[16], 32'h11223344);

        // Latency-1 read: pulse in the next cycle, data held after.
        rd(32'h40);
        chk("l1_rv_pulse", 1, {31'b0, dut_rv[0]}, 32'h1);
        chk("l1_rd_pulse", 1, dut_rd[0], 32'h11223344);
        @(negedge clk);
        chk("l1_rv_after", 1, {31'b0, dut_rv[0]}, 32'h0);
        chk("l1_rd_held", 1, dut_rd[0], 32'h11223344);
        repeat (3) @(negedge clk);

        // Byte-lane writes then an immediate read.
        wr(32'h40, 4'b0001, 32'hAAAAAAAA);
        wr(32'h40, 4'b0100, 32'hBBBBBBBB);
        rd_chk("byte_merge", 32'h40, 32'h11BB33AA);
        chk("mdl_merge", 0, mdl[16], 32'h11BB33AA);

        // Back-to-back reads on latency 3.
        rd(32'h4); rd(32'h8); rd(32'hC);
        chk("l3_b2b_v0", 3, {31'b0, dut_rv[2]}, 32'h1);
        chk("l3_b2b_d0", 3, dut_rd[2], 32'h1);
        @(negedge clk);
        chk("l3_b2b_v1", 3, {31'b0, dut_rv[2]}, 32'h1);
        chk("l3_b2b_d1", 3, dut_rd[2], 32'h2);
        @(negedge clk);
        chk("l3_b2b_v2", 3, {31'b0, dut_rv[2]}, 32'h1);
        chk("l3_b2b_d2", 3, dut_rd[2], 32'h3);
        repeat (3) @(negedge clk);

        // Same-word front write and backdoor write.
        drv(1'b1, 4'b0011, 32'h14, 32'h0000BEEF, 1'b1, 12'h005, 32'hCAFE0000);
        chk("mdl_collide", 0, mdl[5], 32'hCAFEBEEF);
        rd_chk("collide_w5", 32'h14, 32'hCAFEBEEF);

        // Front read racing a backdoor write to the same word.
        drv(1'b1, 4'b0000, 32'h18, 32'h0, 1'b1, 12'h006, 32'h2);
        repeat (4) @(negedge clk);
        for (int l = 0; l < 3; l++) chk("rd_vs_init_old", l + 1, dut_rd[l], 32'h1);
        rd_chk("rd_vs_init_new", 32'h18, 32'h2);

        // Different words in the same cycle both land.
        drv(1'b1, 4'b1111, 32'h1C, 32'h77777777, 1'b1, 12'h008, 32'h88888888);
        rd_chk("dual_w7", 32'h1C, 32'h77777777);
        rd_chk("dual_w8", 32'h20, 32'h88888888);

        // Reset one cycle after a read, with a write presented in the reset cycle.
        rd(32'h40);
        reset = 1'b1;
        drv(1'b1, 4'b1111, 32'h24, 32'h99999999, 1'b0, 12'h0, 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        for (int l = 0; l < 3; l++) chk("post_reset_rdata", l + 1, dut_rd[l], 32'h0);
        rd_chk("write_in_reset", 32'h24, 32'h99999999);
        rd_chk("mem_kept", 32'h40, 32'h11BB33AA);

        // Aliasing and ignored requests.
        wr(32'h0000_4004, 4'b1111, 32'h5A5A5A5A);
        rd_chk("alias_4", 32'h4, 32'h5A5A5A5A);
        rd_chk("alias_7", 32'h7, 32'h5A5A5A5A);
        drv(1'b0, 4'b1111, 32'h4, 32'hDEADBEEF, 1'b0, 12'h0, 32'h0);
        rd_chk("en0_ignored", 32'h4, 32'h5A5A5A5A);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
